// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory bus arbiter.
// Holds the default bus widths and the arbiter state encoding.
// No logic lives here; it is imported by the arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Arbiter sequencing states (2-bit encoding shared with debug tooling).
    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbIf      = 2'd1,
        ArbMem     = 2'd2,
        ArbDiscard = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store, MEM first.
// Latency: request edge N -> bus_req from N+1; ack edge M -> done pulse for the cycle after M.
// Backpressure: bus fields held until bus_ack; requesters see combinational stall_if/stall_mem.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t          state, state_nxt;
    logic                bus_req_nxt;
    logic                bus_we_nxt;
    logic [SEL_W-1:0]    bus_sel_nxt;
    logic [ADDR_W-1:0]   bus_addr_nxt;
    logic [DATA_W-1:0]   bus_wdata_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt;
    logic [DATA_W-1:0]   mem_rdata_nxt;
    logic                if_done_nxt;
    logic                mem_done_nxt;
    logic                mem_elig;
    logic                if_elig;

    // A port whose done is high this cycle is not eligible, so a finished requester is never re-granted.
    assign mem_elig  = mem_req & ~mem_done;
    assign if_elig   = if_req & ~if_done & ~if_flush;
    assign stall_if  = if_elig;
    assign stall_mem = mem_elig;

    // Next-state and next-output logic: grant from IDLE, hold the bus until ack, then report completion.
    always_comb begin
        state_nxt     = state;
        bus_req_nxt   = bus_req;
        bus_we_nxt    = bus_we;
        bus_sel_nxt   = bus_sel;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;
        if_rdata_nxt  = if_rdata;
        mem_rdata_nxt = mem_rdata;
        if_done_nxt   = 1'b0;
        mem_done_nxt  = 1'b0;
        case (state)
            ArbIdle: begin
                // Acks seen here are spurious and ignored. MEM is the older instruction, so it wins.
                if (mem_elig) begin
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = mem_we;
                    bus_sel_nxt   = mem_sel;
                    bus_addr_nxt  = mem_addr;
                    bus_wdata_nxt = mem_wdata;
                    state_nxt     = ArbMem;
                end else if (if_elig) begin
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = 1'b0;
                    bus_sel_nxt   = '1;
                    bus_addr_nxt  = if_addr;
                    bus_wdata_nxt = '0;
                    state_nxt     = ArbIf;
                end
            end
            ArbMem: begin
                if (bus_ack) begin
                    mem_rdata_nxt = bus_rdata;
                    mem_done_nxt  = 1'b1;
                    bus_req_nxt   = 1'b0;
                    state_nxt     = ArbIdle;
                end
            end
            ArbIf: begin
                if (bus_ack) begin
                    bus_req_nxt = 1'b0;
                    state_nxt   = ArbIdle;
                    // A flush landing with the ack kills the returning instruction.
                    if (!if_flush) begin
                        if_rdata_nxt = bus_rdata;
                        if_done_nxt  = 1'b1;
                    end
                end else if (if_flush) begin
                    // The bus cycle cannot be aborted; ride it out and drop the data.
                    state_nxt = ArbDiscard;
                end
            end
            ArbDiscard: begin
                if (bus_ack) begin
                    bus_req_nxt = 1'b0;
                    state_nxt   = ArbIdle;
                end
            end
            default: begin
                bus_req_nxt = 1'b0;
                state_nxt   = ArbIdle;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ArbIdle;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_req   <= bus_req_nxt;
            bus_we    <= bus_we_nxt;
            bus_sel   <= bus_sel_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            mem_rdata <= mem_rdata_nxt;
            if_done   <= if_done_nxt;
            mem_done  <= mem_done_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single external memory bus between instruction fetch (IF) and the load/store stage (MEM).
- Sequences one bus transaction at a time and returns read data to the requesting stage.
- Raises per-stage stall requests; the pipeline stall controller turns these into the `stall` vector used by the PC register and pipeline latches.
- Discards in-flight fetches when a branch redirects the PC.

Parameters:
- ADDR_W, 32, address width of both requester ports and the bus.
- DATA_W, 32, data width; byte-select width is DATA_W/8.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- if_req  input  1  fetch request; level, held until if_done or flush.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_flush  input  1  branch redirect; kill the current or pending fetch.
- if_rdata  output  DATA_W  fetched instruction; valid while if_done is high.
- if_done  output  1  one-cycle pulse: fetch complete.
- mem_req  input  1  data request; level.
- mem_we  input  1  1 = write, 0 = read.
- mem_sel  input  DATA_W/8  byte enables.
- mem_addr  input  ADDR_W  data address.
- mem_wdata  input  DATA_W  write data.
- mem_rdata  output  DATA_W  read data; valid while mem_done is high.
- mem_done  output  1  one-cycle pulse: data access complete.
- stall_if  output  1  IF waiting; combinational: if_req & ~if_done & ~if_flush.
- stall_mem  output  1  MEM waiting; combinational: mem_req & ~mem_done.
- bus_req  output  1  bus request; registered.
- bus_we  output  1  bus write enable; registered.
- bus_sel  output  DATA_W/8  bus byte enables; registered.
- bus_addr  output  ADDR_W  bus address; registered.
- bus_wdata  output  DATA_W  bus write data; registered.
- bus_rdata  input  DATA_W  bus read data; valid in the ack cycle.
- bus_ack  input  1  one-cycle transaction-complete strobe.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - bus_req, bus_we, if_done, mem_done = 0.
  - bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata = 0.
- FSM states:
  - IDLE, IF_BUSY, MEM_BUSY, IF_DISCARD.
- IDLE, evaluated at the posedge:
  - Eligible requesters: mem_req with mem_done=0; if_req with if_done=0 and if_flush=0.
  - MEM beats IF: the older instruction wins.
  - Grant MEM: load bus_* from mem_*, bus_req<=1, go to MEM_BUSY.
  - Grant IF: bus_addr<=if_addr, bus_we<=0, bus_sel<=all ones, bus_wdata<=0, bus_req<=1, go to IF_BUSY.
  - No eligible requester: stay in IDLE.
- Bus handshake:
  - bus_req and the bus_* fields are held constant until bus_ack is sampled high.
  - On ack: bus_req<=0, return to IDLE.
  - Exactly one transaction per grant; no back-to-back issue, so at least one IDLE cycle between transactions.
- MEM_BUSY:
  - On bus_ack: mem_rdata<=bus_rdata (write transactions capture it too, value don't-care).
  - mem_done<=1 for exactly one cycle.
- IF_BUSY:
  - bus_ack with no if_flush: if_rdata<=bus_rdata, if_done<=1 for one cycle.
  - if_flush with no bus_ack: go to IF_DISCARD; the bus cycle is not aborted and bus_req stays high.
  - bus_ack and if_flush in the same cycle: data discarded, if_done stays 0, go to IDLE.
- IF_DISCARD:
  - Wait for bus_ack, then go to IDLE; no if_done, if_rdata unchanged.
  - Further if_flush pulses are ignored.
- Latency:
  - Request sampled at edge N; bus_req high from N+1.
  - Ack sampled at edge M; done high during cycle M+1 to M+2.
  - Zero-wait bus (ack in the first bus_req cycle): done 2 cycles after the request edge.
- Done-cycle rule: requesters drop or replace req during the done cycle; the arbiter never re-grants a port whose done is high.
- Latency bound: IF waits at most one MEM transaction. MEM stalls the pipeline, so no new MEM request arrives until IF progresses; there is no starvation.
- mem_req arriving during IF_BUSY: stall_mem=1 until the IF completes, then MEM is granted from IDLE.
- bus_ack while in IDLE (spurious): ignored.
- Reset mid-transaction: all outputs return to reset values immediately; the bus slave is also reset.

Decomposition:
- Shared defines (existing include file): bus address/data widths and the FSM state encoding as 2-bit constants (ArbIdle, ArbIf, ArbMem, ArbDiscard).
- Single module; no sub-module needed. The stall vector stays in the existing stall controller, which consumes stall_if/stall_mem.

Test Plan:
- IF only, ack latency 3: if_req=1, if_addr=0x0000_0010, bus_rdata=0x0013_0093 → bus_req high 3 cycles, bus_addr=0x10, bus_sel=0xF, bus_we=0; if_done pulses 1 cycle with if_rdata=0x0013_0093; stall_if=1 until then.
- Simultaneous requests, same edge: if_req (0x20) and mem_req write (addr 0x100, wdata 0xDEADBEEF, sel 0x3) → MEM issued first with bus_we=1, bus_sel=0x3; after mem_done, one IDLE cycle, then IF issued at 0x20.
- Flush mid-fetch: IF granted at 0x40, if_flush on bus cycle 1, ack on cycle 4 → state IF_DISCARD, bus_req held through ack, no if_done pulse; a new if_req at 0x80 is granted after returning to IDLE.
- Flush coincident with ack → if_done stays 0, if_rdata retains its previous value.
- Zero-wait bus: bus_ack tied high during bus_req, mem read 0x200 → mem_done exactly 2 cycles after the request edge, mem_rdata captured.
- Async reset asserted between edges while in MEM_BUSY → bus_req, mem_done, if_done go low immediately; after release, state is IDLE and the pending mem_req is re-granted.
